uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` transmitter between `N_REQ` byte-producing requesters. It accepts requests, captures the granted requester's byte, and drives the transmitter's `data`/`send` inputs. It then tracks the transmitter's `ready` through a full frame and reports completion back to the owning requester. The arbiter sits between client logic (command/status sources) and the `uart_tx` instance, in the same `clk` domain. The transmitter's line configuration (baud, size, parity, stop bits) is wired around this block and is not touched by it.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signals of the shared uart_tx arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic [OW-1:0]      owner;
  logic               busy;
  logic               timeout_err;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic               tx_ready;

  modport master (
    output req, data_in, tx_ready,
    input  grant, done, owner, busy, timeout_err, tx_data, tx_send
  );

  modport slave (
    input  req, data_in, tx_ready,
    output grant, done, owner, busy, timeout_err, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte producers; tracks tx_ready
// through each frame and reports done (or a timeout) back to the owner.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  // state | meaning
  // IDLE  | arbitrate when tx_ready ; ISSUE | tx_send held ; WAIT | frame on the line
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [OW-1:0]    r_ptr, w_ptr_nxt;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic             r_busy;
  logic             r_to_err, w_to_err_nxt;
  logic             r_tx_send, w_tx_send_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic [7:0]       w_bytes [N_REQ];
  logic [OW-1:0]    w_idx;
  logic [OW-1:0]    w_win;
  logic             w_found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = bus.data_in[8*gi +: 8];
  end

  // First active request at or after ptr; OW-bit arithmetic wraps since N_REQ is a power of two.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = r_ptr + OW'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_tx_data_nxt = r_tx_data;
    w_tx_send_nxt = r_tx_send;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = '0;
    w_done_nxt    = '0;
    w_to_err_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tx_ready && w_found) begin
          w_grant_nxt   = N_REQ'(1) << w_win;
          w_tx_data_nxt = w_bytes[w_win];
          w_tx_send_nxt = 1'b1;
          w_owner_nxt   = w_win;
          w_ptr_nxt     = w_win + OW'(1);
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.tx_ready) begin
          w_tx_send_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_WAIT;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_tx_send_nxt = 1'b0;
          w_to_err_nxt  = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_WAIT: begin
        if (bus.tx_ready) begin
          w_done_nxt  = N_REQ'(1) << r_owner;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_to_err  <= 1'b0;
      r_tx_send <= 1'b0;
      r_tx_data <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_to_err  <= w_to_err_nxt;
      r_tx_send <= w_tx_send_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.owner       = r_owner;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_to_err;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_send     = r_tx_send;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter-ready model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  localparam int K_GRANT = 0, K_DONE = 1, K_TO = 2;
  localparam int M_AUTO = 0, M_STUCK1 = 1, M_STUCK0 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus_if ();
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    int kind;
    int idx;
    int data;
  } ev_t;
  ev_t q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_grant = 0, n_done = 0, n_to = 0;
  int cyc = 0;
  int last_end_cyc = -10;
  int last_grant_cyc = 0;
  int rise_cyc = 0;
  int send_run = 0, last_w = 0;
  int mode_cmd = M_AUTO;
  int fall_dly = 10, low_len = 100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input int data);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor/scoreboard and transmitter model share one negedge process.
  initial begin
    ev_t e;
    int cur_mode = M_AUTO;
    int mst = 0;
    int mcnt = 0;
    bus_if.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus_if.grant != '0) begin
          if (q.size() == 0) chk("unexp_grant", 32'(bus_if.grant), 0);
          else begin
            e = q.pop_front();
            chk("grant_kind", K_GRANT, e.kind);
            chk("grant_vec", 32'(bus_if.grant), 32'(1) << e.idx);
            chk("grant_data", 32'(bus_if.tx_data), e.data);
            chk("grant_owner", 32'(bus_if.owner), e.idx);
            chk("grant_busy", 32'(bus_if.busy), 1);
            chk("grant_send", 32'(bus_if.tx_send), 1);
            chk("idle_gap", 32'(cyc > last_end_cyc), 1);
          end
          n_grant++;
          last_grant_cyc = cyc;
        end
        if (bus_if.done != '0) begin
          if (q.size() == 0) chk("unexp_done", 32'(bus_if.done), 0);
          else begin
            e = q.pop_front();
            chk("done_kind", K_DONE, e.kind);
            chk("done_vec", 32'(bus_if.done), 32'(1) << e.idx);
            chk("done_data", 32'(bus_if.tx_data), e.data);
            chk("done_overlap", 32'(bus_if.grant), 0);
            chk("done_busy", 32'(bus_if.busy), 0);
          end
          n_done++;
          last_end_cyc = cyc;
        end
        if (bus_if.timeout_err) begin
          if (q.size() == 0) chk("unexp_timeout", 1, 0);
          else begin
            e = q.pop_front();
            chk("to_kind", K_TO, e.kind);
            chk("to_busy", 32'(bus_if.busy), 0);
            chk("to_send", 32'(bus_if.tx_send), 0);
          end
          n_to++;
          last_end_cyc = cyc;
        end
      end
      if (bus_if.tx_send) send_run++;
      else if (send_run > 0) begin
        last_w = send_run;
        send_run = 0;
      end
      if (mode_cmd != cur_mode) begin
        cur_mode = mode_cmd;
        mst = 0;
      end
      case (cur_mode)
        M_STUCK1: bus_if.tx_ready = 1'b1;
        M_STUCK0: bus_if.tx_ready = 1'b0;
        default: begin
          case (mst)
            0: begin
              if (!bus_if.tx_ready) rise_cyc = cyc;
              bus_if.tx_ready = 1'b1;
              if (bus_if.tx_send) begin
                mst = 1;
                mcnt = fall_dly;
              end
            end
            1: begin
              mcnt--;
              if (mcnt == 0) begin
                bus_if.tx_ready = 1'b0;
                mst = 2;
                mcnt = low_len;
              end
            end
            default: begin
              mcnt--;
              if (mcnt == 0) begin
                bus_if.tx_ready = 1'b1;
                rise_cyc = cyc;
                mst = 0;
              end
            end
          endcase
        end
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input string tag, input int which, input int target, input int budget);
    int v;
    for (int i = 0; i < budget; i++) begin
      v = (which == K_GRANT) ? n_grant : (which == K_DONE) ? n_done : n_to;
      if (v >= target) break;
      step();
    end
    v = (which == K_GRANT) ? n_grant : (which == K_DONE) ? n_done : n_to;
    chk(tag, v, target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(bus_if.grant), 0);
    chk({tag, "_done"}, 32'(bus_if.done), 0);
    chk({tag, "_busy"}, 32'(bus_if.busy), 0);
    chk({tag, "_toerr"}, 32'(bus_if.timeout_err), 0);
    chk({tag, "_send"}, 32'(bus_if.tx_send), 0);
    chk({tag, "_data"}, 32'(bus_if.tx_data), 0);
    chk({tag, "_owner"}, 32'(bus_if.owner), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus_if.req = '0;
    bus_if.data_in = '0;
    repeat (3) step();
    chk_reset_vals("rst");
    rst = 1'b0;

    // single request, ready falls 10 cycles after send, low for 100
    bus_if.data_in = {8'h44, 8'h33, 8'h22, 8'h55};
    push(K_GRANT, 0, 8'h55);
    push(K_DONE, 0, 8'h55);
    bus_if.req = 4'b0001;
    wait_for("single_grant", K_GRANT, 1, 20);
    bus_if.req = '0;
    wait_for("single_done", K_DONE, 1, 300);
    chk("single_send_w", last_w, 11);
    step();
    chk("single_busy_after", 32'(bus_if.busy), 0);

    // round robin from ptr=0, all requests held
    rst = 1'b1;
    step();
    rst = 1'b0;
    fall_dly = 2;
    low_len = 5;
    bus_if.data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 5; i++) begin
      push(K_GRANT, i % N, 8'hA0 + i % N);
      push(K_DONE, i % N, 8'hA0 + i % N);
    end
    base = n_done;
    bus_if.req = 4'b1111;
    wait_for("rr_done", K_DONE, base + 5, 400);
    bus_if.req = '0;

    // skip and wrap: ptr=1 -> grant 2 (ptr=3) -> 3,1 -> 2 -> 3,0
    push(K_GRANT, 2, 8'hA2); push(K_DONE, 2, 8'hA2);
    bus_if.req = 4'b0100;
    wait_for("skip_a", K_DONE, n_done + 1, 100);
    bus_if.req = '0;
    push(K_GRANT, 3, 8'hA3); push(K_DONE, 3, 8'hA3);
    push(K_GRANT, 1, 8'hA1); push(K_DONE, 1, 8'hA1);
    bus_if.req = 4'b1010;
    wait_for("wrap_b", K_DONE, n_done + 2, 100);
    bus_if.req = '0;
    push(K_GRANT, 2, 8'hA2); push(K_DONE, 2, 8'hA2);
    bus_if.req = 4'b0100;
    wait_for("skip_c", K_DONE, n_done + 1, 100);
    bus_if.req = '0;
    push(K_GRANT, 3, 8'hA3); push(K_DONE, 3, 8'hA3);
    push(K_GRANT, 0, 8'hA0); push(K_DONE, 0, 8'hA0);
    bus_if.req = 4'b1001;
    wait_for("wrap_d", K_DONE, n_done + 2, 100);
    bus_if.req = '0;

    // timeout with ready stuck high, then next requester completes normally
    mode_cmd = M_STUCK1;
    step();
    push(K_GRANT, 1, 8'hA1);
    push(K_TO, 1, 0);
    push(K_GRANT, 2, 8'hA2);
    push(K_DONE, 2, 8'hA2);
    bus_if.req = 4'b0110;
    wait_for("to_pulse", K_TO, n_to + 1, 60);
    chk("to_send_w", last_w, TO);
    mode_cmd = M_AUTO;
    wait_for("to_next_done", K_DONE, n_done + 1, 100);
    bus_if.req = '0;

    // transmitter busy while a request is pending
    mode_cmd = M_STUCK0;
    repeat (2) step();
    base = n_grant;
    bus_if.req = 4'b0010;
    repeat (6) step();
    chk("busy_no_grant", n_grant, base);
    push(K_GRANT, 1, 8'hA1);
    push(K_DONE, 1, 8'hA1);
    mode_cmd = M_AUTO;
    wait_for("busy_grant", K_GRANT, base + 1, 20);
    chk("busy_grant_lat", last_grant_cyc - rise_cyc, 1);
    bus_if.req = '0;
    wait_for("busy_done", K_DONE, n_done + 1, 100);

    // reset during WAIT: no done, ptr back to 0
    low_len = 50;
    push(K_GRANT, 0, 8'hA0);
    bus_if.req = 4'b0001;
    wait_for("mid_grant", K_GRANT, n_grant + 1, 20);
    bus_if.req = '0;
    repeat (8) step();
    chk("mid_in_wait_busy", 32'(bus_if.busy), 1);
    chk("mid_in_wait_send", 32'(bus_if.tx_send), 0);
    base = n_done;
    rst = 1'b1;
    step();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    repeat (60) step();
    chk("mid_no_done", n_done, base);
    push(K_GRANT, 0, 8'hA0);
    push(K_DONE, 0, 8'hA0);
    bus_if.req = 4'b0011;
    wait_for("mid_ptr0_grant", K_GRANT, n_grant + 1, 100);
    bus_if.req = '0;
    wait_for("mid_ptr0_done", K_DONE, base + 1, 100);

    repeat (5) step();
    chk("queue_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_errors);
    $fatal(1);
  end
endmodule
